// File: rtl/matrix_storage_bank_if.sv
// Arbiter-to-storage-bank bus: address/data/strobes in, read data and status out.
// Parameters must match the matrix_storage_bank instance that uses it.
interface matrix_storage_bank_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
);
   logic [ADDR_W-1:0] i_addr;
   logic [DATA_W-1:0] i_data;
   logic              i_we;
   logic              i_re;
   logic              i_clear_req;
   logic              i_par_inject;
   logic [DATA_W-1:0] o_rdata;
   logic              o_rvalid;
   logic              o_busy;
   logic              o_clear_done;
   logic [CNT_W-1:0]  o_wr_count;
   logic              o_par_err;

   modport master (
      output i_addr, i_data, i_we, i_re,
      output i_clear_req, i_par_inject,
      input  o_rdata, o_rvalid, o_busy,
      input  o_clear_done, o_wr_count, o_par_err
   );

   modport slave (
      input  i_addr, i_data, i_we, i_re,
      input  i_clear_req, i_par_inject,
      output o_rdata, o_rvalid, o_busy,
      output o_clear_done, o_wr_count, o_par_err
   );
endinterface

// File: rtl/matrix_storage_bank.sv
// Matrix word store with registered reads, bulk-clear sweep and write counter.
// Define MATRIX_STORAGE_PARITY_EN to add a per-word even-parity bit.
module matrix_storage_bank #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   matrix_storage_bank_if.slave  bus
);
   localparam int DEPTH = 1 << ADDR_W;
`ifdef MATRIX_STORAGE_PARITY_EN
   localparam int MEM_W = DATA_W + 1;
`else
   localparam int MEM_W = DATA_W;
`endif

   typedef enum logic [1:0] {
      IDLE,
      CLEAR,
      DONE
   } state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              rvalid_q, rvalid_d;
   logic              perr_q, perr_d;

   logic [MEM_W-1:0]  mem [DEPTH];
   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [MEM_W-1:0]  mem_wdata;
   logic [MEM_W-1:0]  wr_word;
   logic [MEM_W-1:0]  rd_word;

`ifdef MATRIX_STORAGE_PARITY_EN
   assign wr_word = {^bus.i_data ^ bus.i_par_inject, bus.i_data};
`else
   logic unused_par_inject;
   assign unused_par_inject = bus.i_par_inject;
   assign wr_word = bus.i_data;
`endif

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      rdata_d   = rdata_q;
      rvalid_d  = 1'b0;
      perr_d    = 1'b0;
      mem_we    = 1'b0;
      mem_waddr = bus.i_addr;
      mem_wdata = wr_word;
      rd_word   = mem[bus.i_addr];
      unique case (state_q)
         IDLE, DONE: begin
            if (bus.i_we) begin
               mem_we = 1'b1;
               if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
            end
            if (bus.i_re) begin
               // same-address write bypasses the array
               if (bus.i_we) rd_word = wr_word;
               rvalid_d = 1'b1;
               rdata_d  = rd_word[DATA_W-1:0];
`ifdef MATRIX_STORAGE_PARITY_EN
               perr_d   = ^rd_word;
`endif
            end
            if (state_q == DONE) begin
               state_d = IDLE;
            end else if (bus.i_clear_req) begin
               state_d = CLEAR;
            end
         end
         CLEAR: begin
            mem_we    = 1'b1;
            mem_waddr = ptr_q;
            mem_wdata = '0;
            ptr_d     = ptr_q + 1'b1;
            if (&ptr_q) begin
               state_d = DONE;
               cnt_d   = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         ptr_q    <= '0;
         cnt_q    <= '0;
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
         perr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         cnt_q    <= cnt_d;
         rdata_q  <= rdata_d;
         rvalid_q <= rvalid_d;
         perr_q   <= perr_d;
      end
   end

   // array contents survive reset
   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
   end

   assign bus.o_rdata      = rdata_q;
   assign bus.o_rvalid     = rvalid_q;
   assign bus.o_busy       = (state_q == CLEAR);
   assign bus.o_clear_done = (state_q == DONE);
   assign bus.o_wr_count   = cnt_q;
   assign bus.o_par_err    = perr_q;
endmodule

// File: tb/tb_matrix_storage_bank.sv
// Random + directed bench for matrix_storage_bank against a behavioural model.
// Honours MATRIX_STORAGE_PARITY_EN the same way as the design.
module tb_matrix_storage_bank;
  localparam int AW    = 8;
  localparam int DW    = 32;
  localparam int CW    = 16;
  localparam int DEPTH = 256;
`ifdef MATRIX_STORAGE_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  matrix_storage_bank_if #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) bus();

  matrix_storage_bank #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // behavioural model
  logic [DW-1:0] m_data [DEPTH];
  logic          m_par  [DEPTH];
  bit            m_known[DEPTH];
  int            clr_left = 0;
  bit            in_done = 0;
  bit            was_done;
  logic [DW-1:0] e_rdata = '0;
  bit            e_rd_known = 1'b1;
  logic          e_rvalid = 1'b0;
  logic          e_perr = 1'b0;
  logic [CW-1:0] e_cnt = '0;
  int            ma;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_left   = 0;
      in_done    = 0;
      e_rdata    = '0;
      e_rd_known = 1'b1;
      e_rvalid   = 1'b0;
      e_perr     = 1'b0;
      e_cnt      = '0;
    end else if (clr_left > 0) begin
      ma = DEPTH - clr_left;
      m_data[ma]  = '0;
      m_par[ma]   = 1'b0;
      m_known[ma] = 1'b1;
      clr_left--;
      e_rvalid = 1'b0;
      e_perr   = 1'b0;
      if (clr_left == 0) begin
        in_done = 1;
        e_cnt   = '0;
      end
    end else begin
      was_done = in_done;
      in_done  = 0;
      ma       = int'(bus.i_addr);
      e_rvalid = bus.i_re;
      e_perr   = 1'b0;
      if (bus.i_re) begin
        if (bus.i_we) begin
          e_rdata    = bus.i_data;
          e_rd_known = 1'b1;
          e_perr     = PAR && bus.i_par_inject;
        end else begin
          e_rdata    = m_data[ma];
          e_rd_known = m_known[ma];
          e_perr     = PAR && ((^m_data[ma]) != m_par[ma]);
        end
      end
      if (bus.i_we) begin
        m_data[ma]  = bus.i_data;
        m_par[ma]   = (^bus.i_data) ^ bus.i_par_inject;
        m_known[ma] = 1'b1;
        if (e_cnt != '1) e_cnt = e_cnt + 1'b1;
      end
      if (bus.i_clear_req && !was_done) clr_left = DEPTH;
    end
  end

  // compare process
  always @(negedge clk) begin
    if (rst_n) begin
      chk("rvalid", bus.o_rvalid, e_rvalid);
      chk("busy", bus.o_busy, clr_left > 0);
      chk("clear_done", bus.o_clear_done, in_done);
      chk("wr_count", bus.o_wr_count, e_cnt);
      if (e_rd_known) chk("rdata", bus.o_rdata, e_rdata);
      if (e_rd_known || !e_rvalid) chk("par_err", bus.o_par_err, e_perr);
    end
  end

  task automatic step(bit we, bit re, logic [AW-1:0] a,
                      logic [DW-1:0] d, bit clr, bit inj);
    @(negedge clk);
    bus.i_we         = we;
    bus.i_re         = re;
    bus.i_addr       = a;
    bus.i_data       = d;
    bus.i_clear_req  = clr;
    bus.i_par_inject = inj;
  endtask

  task automatic idle();
    step(0, 0, '0, '0, 0, 0);
  endtask

  task automatic chk_zero(string nm);
    chk({nm, "_rdata"}, bus.o_rdata, 0);
    chk({nm, "_rvalid"}, bus.o_rvalid, 0);
    chk({nm, "_busy"}, bus.o_busy, 0);
    chk({nm, "_done"}, bus.o_clear_done, 0);
    chk({nm, "_cnt"}, bus.o_wr_count, 0);
    chk({nm, "_perr"}, bus.o_par_err, 0);
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  int  busycnt;
  bit  seen;
  int  guard;

  initial begin
    bus.i_we = 0; bus.i_re = 0; bus.i_addr = '0; bus.i_data = '0;
    bus.i_clear_req = 0; bus.i_par_inject = 0;
    #2 rst_n = 1'b0;
    #1 chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // write then read back
    step(1, 0, 8'h05, 32'hDEADBEEF, 0, 0);
    step(0, 1, 8'h05, '0, 0, 0);
    idle();
    chk("t1_rvalid", bus.o_rvalid, 1);
    chk("t1_rdata", bus.o_rdata, 32'hDEADBEEF);
    chk("t1_cnt", bus.o_wr_count, 1);
    idle();
    chk("t1_rvalid_off", bus.o_rvalid, 0);
    chk("t1_hold", bus.o_rdata, 32'hDEADBEEF);

    // same-address write-through
    step(1, 0, 8'h10, 32'hAAAAAAAA, 0, 0);
    step(1, 1, 8'h10, 32'h12345678, 0, 0);
    idle();
    chk("t2_rdata", bus.o_rdata, 32'h12345678);
    chk("t2_cnt", bus.o_wr_count, 3);

    // full clear with traffic ignored while busy
    step(1, 0, 8'h00, 32'hFFFFFFFF, 0, 0);
    step(1, 0, 8'hFF, 32'hFFFFFFFF, 0, 0);
    step(0, 0, '0, '0, 1, 0);
    busycnt = 0;
    seen = 0;
    for (int i = 0; i < 400; i++) begin
      step($urandom % 2, $urandom % 2, AW'($urandom), $urandom, 0, 0);
      if (bus.o_busy) busycnt++;
      if (bus.o_clear_done) begin
        seen = 1;
        chk("t3_cnt_done", bus.o_wr_count, 0);
        bus.i_we = 0;
        bus.i_re = 0;
        break;
      end
    end
    chk("t3_done_seen", seen, 1);
    chk("t3_busy_cycles", busycnt, 256);
    step(0, 1, 8'h00, '0, 0, 0);
    step(0, 1, 8'hFF, '0, 0, 0);
    chk("t3_rd00", bus.o_rdata, 0);
    chk("t3_rv00", bus.o_rvalid, 1);
    idle();
    chk("t3_rdFF", bus.o_rdata, 0);
    chk("t3_cnt", bus.o_wr_count, 0);

    // reset in the middle of a clear
    step(0, 0, '0, '0, 1, 0);
    repeat (100) idle();
    #3 rst_n = 1'b0;
    #1 chk_zero("t4_rst");
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 0, 8'h20, 32'h00000055, 0, 0);
    step(0, 1, 8'h20, '0, 0, 0);
    idle();
    chk("t4_cnt", bus.o_wr_count, 1);
    chk("t4_rdata", bus.o_rdata, 32'h55);
    chk("t4_busy", bus.o_busy, 0);

    // parity injection
    step(1, 0, 8'h03, 32'h00000001, 0, 1);
    step(0, 1, 8'h03, '0, 0, 0);
    idle();
    chk("t5_rv", bus.o_rvalid, 1);
    chk("t5_perr_inj", bus.o_par_err, PAR);
    step(1, 0, 8'h03, 32'h00000001, 0, 0);
    step(0, 1, 8'h03, '0, 0, 0);
    idle();
    chk("t5_perr_clean", bus.o_par_err, 0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom % 2, $urandom % 2,
           ($urandom % 4 == 0) ? AW'($urandom) : AW'($urandom % 16),
           $urandom, ($urandom % 300) == 0, ($urandom % 8) == 0);
    end
    idle();
    guard = 0;
    while ((bus.o_busy || bus.o_clear_done) && guard < 300) begin
      idle();
      guard++;
    end
    chk("settle_timeout", guard < 300, 1);

    // counter saturation
    for (int i = 0; i < 65540; i++) begin
      step(1, 0, AW'($urandom), $urandom, 0, 0);
    end
    idle();
    chk("t6_sat", bus.o_wr_count, 16'hFFFF);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/matrix_storage_bank.md
Name: matrix_storage_bank

Overview:
- Storage responder at the far end of the storage arbitration path.
- Accepts one address/data/write-enable stream per cycle from the arbiter and holds matrix words in a synchronous RAM.
- Returns registered read data with a valid strobe.
- Provides a hardware bulk-clear sequencer and a count of accepted writes, used by the control FSM.

Parameters:
ADDR_W, 8, address width; depth = 2**ADDR_W words
DATA_W, 32, word width
CNT_W, 16, width of the accepted-write counter

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
i_addr  input  ADDR_W  word address from the storage arbiter
i_data  input  DATA_W  write data
i_we  input  1  write enable, one word per cycle
i_re  input  1  read request; data is returned next cycle
i_clear_req  input  1  single-cycle pulse that starts a bulk clear
i_par_inject  input  1  flips the stored parity bit of the current write (test only)
o_rdata  output  DATA_W  registered read data
o_rvalid  output  1  o_rdata valid, one-cycle pulse
o_busy  output  1  high while a clear is in progress
o_clear_done  output  1  one-cycle pulse when a clear completes
o_wr_count  output  CNT_W  count of accepted writes, saturating
o_par_err  output  1  parity mismatch on the returned word

Behaviour:
- Reset is asserted asynchronously. While rst_n=0:
  - o_rdata=0, o_rvalid=0, o_busy=0, o_clear_done=0, o_wr_count=0, o_par_err=0.
  - FSM is in IDLE and the sweep pointer is 0.
  - RAM contents are not reset; they are undefined until written or cleared.
- FSM states and transitions:
  - IDLE -> CLEAR on i_clear_req=1.
  - CLEAR -> DONE after the word at address DEPTH-1 is written.
  - DONE -> IDLE after exactly one cycle.
- IDLE, write path:
  - If i_we=1, mem[i_addr] <= i_data at the clock edge.
  - o_wr_count increments by 1 and saturates at 2**CNT_W-1.
- IDLE, read path:
  - If i_re=1, the next cycle has o_rvalid=1 and o_rdata = mem[i_addr].
  - Read latency is exactly 1 cycle. o_rdata holds its value when o_rvalid=0.
- Same-cycle i_we=1 and i_re=1 at the same address: write-through. o_rdata returns the new i_data.
- Different addresses in the same cycle: both operations are performed.
- CLEAR:
  - o_busy=1.
  - The sweep pointer writes 0 to one address per cycle, 0 through DEPTH-1, taking DEPTH cycles (256 at default).
  - i_we, i_re and i_clear_req are ignored, and o_rvalid stays 0.
- DONE:
  - o_clear_done=1 and o_busy=0.
  - o_wr_count resets to 0.
  - i_we and i_re are serviced normally in this cycle.
- Clear request arriving with i_we in the same IDLE cycle: the write is performed, then the clear overwrites it.
- A read request issued in the same cycle as i_clear_req still returns its data the next cycle.
- Reset asserted mid-clear aborts the clear. Partially cleared RAM is allowed; o_busy drops immediately.
- Addresses are always in range: depth is a power of two, so no wrap logic is needed.

Optional Feature:
- Macro: MATRIX_STORAGE_PARITY_EN.
- When defined:
  - Each RAM word carries an extra even-parity bit, computed as ^i_data XOR i_par_inject at write time.
  - A clear writes parity 0.
  - On a read, o_par_err = (^word != stored parity), asserted coincident with o_rvalid. It is 0 whenever o_rvalid=0.
- When not defined:
  - No parity storage.
  - o_par_err is tied to 0 and i_par_inject is ignored.

Test Plan:
- Reset, write 0xDEADBEEF to address 0x05, then read 0x05 -> rvalid exactly 1 cycle after re, rdata=0xDEADBEEF, wr_count=1.
- Same cycle: we=1, re=1, address 0x10, data 0x12345678, where address 0x10 previously held 0xAAAAAAAA -> next cycle rdata=0x12345678.
- Write 0xFFFFFFFF to 0x00 and 0xFF, pulse clear_req -> busy high for 256 cycles, clear_done for 1 cycle, wr_count=0, reads of 0x00 and 0xFF return 0; we and re issued during busy have no effect and produce no rvalid.
- Start a clear, assert rst_n=0 at cycle 100 -> busy=0 and all outputs 0 asynchronously; after release, the FSM is in IDLE and accepts writes.
- Issue 65540 writes with CNT_W=16 -> wr_count saturates at 0xFFFF.
- With MATRIX_STORAGE_PARITY_EN: write 0x00000001 with par_inject=1, then read -> par_err=1 with rvalid. Rewrite with par_inject=0 -> par_err=0. Without the macro, par_err stays 0.
